// File: rtl/idex_stage_reg.sv
// idex_stage_reg: ID/EX pipeline register with ALU decode, stall/flush and bubble counting.
// Illegal decodes still advance as valid so the trap logic sees them, but with WB/Mem suppressed.
module idex_stage_reg #(
    parameter int XLEN  = 32,
    parameter int RA_W  = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             valid_i,
    input  logic [XLEN-1:0]  rs1_data_i,
    input  logic [XLEN-1:0]  rs2_data_i,
    input  logic [XLEN-1:0]  Iimm_i,
    input  logic [XLEN-1:0]  Simm_i,
    input  logic [RA_W-1:0]  rs1_addr_i,
    input  logic [RA_W-1:0]  rs2_addr_i,
    input  logic [RA_W-1:0]  rd_addr_i,
    input  logic [2:0]       funct3_i,
    input  logic [6:0]       funct7_i,
    input  logic [1:0]       ALUOp_i,
    input  logic             ALUSrc_i,
    input  logic             WB_i,
    input  logic [1:0]       Mem_i,
    output logic             valid_o,
    output logic [XLEN-1:0]  val1_o,
    output logic [XLEN-1:0]  val2_o,
    output logic [XLEN-1:0]  rs2_data_o,
    output logic [XLEN-1:0]  Simm_o,
    output logic [RA_W-1:0]  rs1_addr_o,
    output logic [RA_W-1:0]  rs2_addr_o,
    output logic [RA_W-1:0]  rd_addr_o,
    output logic [3:0]       ALUCtrl_o,
    output logic             WB_o,
    output logic [1:0]       Mem_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] bubble_cnt_o
);
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SLL = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SRA = 4'b0111;
    localparam logic [3:0] ALU_SLT = 4'b1000;
    localparam logic [3:0] ALU_MUL = 4'b1111;

    logic [3:0] dec_alu;
    logic       dec_ill;
    logic       bubble;

    always_comb begin
        dec_alu = ALU_ADD;
        dec_ill = 1'b0;
        if (ALUOp_i == 2'b01)
            dec_alu = ALU_SUB;
        else if (ALUOp_i == 2'b10)
            case ({funct7_i, funct3_i})
                10'b0000000_000: dec_alu = ALU_ADD;
                10'b0100000_000: dec_alu = ALU_SUB;
                10'b0000000_111: dec_alu = ALU_AND;
                10'b0000000_110: dec_alu = ALU_OR;
                10'b0000000_100: dec_alu = ALU_XOR;
                10'b0000000_001: dec_alu = ALU_SLL;
                10'b0000000_101: dec_alu = ALU_SRL;
                10'b0100000_101: dec_alu = ALU_SRA;
                10'b0000000_010: dec_alu = ALU_SLT;
                10'b0000001_000: dec_alu = ALU_MUL;
                default:         dec_ill = 1'b1;
            endcase
        else if (ALUOp_i == 2'b11)
            case (funct3_i)
                3'b000:  dec_alu = ALU_ADD;
                3'b111:  dec_alu = ALU_AND;
                3'b110:  dec_alu = ALU_OR;
                3'b100:  dec_alu = ALU_XOR;
                3'b010:  dec_alu = ALU_SLT;
                3'b001:  begin
                    dec_alu = funct7_i == 7'b0000000 ? ALU_SLL : ALU_ADD;
                    dec_ill = funct7_i != 7'b0000000;
                end
                3'b101:  begin
                    dec_alu = funct7_i == 7'b0000000 ? ALU_SRL :
                              funct7_i == 7'b0100000 ? ALU_SRA : ALU_ADD;
                    dec_ill = funct7_i != 7'b0000000 && funct7_i != 7'b0100000;
                end
                default: dec_ill = 1'b1;
            endcase
    end

    assign bubble = flush_i || (!stall_i && !valid_i);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_o      <= 1'b0;
            val1_o       <= '0;
            val2_o       <= '0;
            rs2_data_o   <= '0;
            Simm_o       <= '0;
            rs1_addr_o   <= '0;
            rs2_addr_o   <= '0;
            rd_addr_o    <= '0;
            ALUCtrl_o    <= '0;
            WB_o         <= 1'b0;
            Mem_o        <= '0;
            illegal_o    <= 1'b0;
            bubble_cnt_o <= '0;
        end else if (bubble) begin
            valid_o      <= 1'b0;
            val1_o       <= '0;
            val2_o       <= '0;
            rs2_data_o   <= '0;
            Simm_o       <= '0;
            rs1_addr_o   <= '0;
            rs2_addr_o   <= '0;
            rd_addr_o    <= '0;
            ALUCtrl_o    <= ALU_ADD;
            WB_o         <= 1'b0;
            Mem_o        <= '0;
            illegal_o    <= 1'b0;
            bubble_cnt_o <= &bubble_cnt_o ? bubble_cnt_o : bubble_cnt_o + 1'b1;
        end else if (!stall_i) begin
            valid_o      <= 1'b1;
            val1_o       <= rs1_data_i;
            val2_o       <= ALUSrc_i ? Iimm_i : rs2_data_i;
            rs2_data_o   <= rs2_data_i;
            Simm_o       <= Simm_i;
            rs1_addr_o   <= rs1_addr_i;
            rs2_addr_o   <= rs2_addr_i;
            rd_addr_o    <= rd_addr_i;
            ALUCtrl_o    <= dec_alu;
            WB_o         <= WB_i && !dec_ill;
            Mem_o        <= dec_ill ? 2'b00 : Mem_i;
            illegal_o    <= dec_ill;
        end
    end
endmodule

// File: doc/idex_stage_reg.md
Name: idex_stage_reg

Overview:
- Parametrised successor to the ID/EX pipeline register of the RISC-V core.
- Captures decoded operands, immediates, register addresses and WB/Mem control each cycle.
- Generates the 4-bit ALU control code from ALUOp/funct, including a new I-type decode mode and illegal-funct detection.
- Adds a valid bit, hazard-unit stall (hold) and branch flush (bubble), a saturating bubble counter, and a separate rs2 data path for stores.

Parameters:
- XLEN, 32, operand/immediate width.
- RA_W, 5, register address width.
- CNT_W, 16, bubble counter width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- stall_i  in  1  hold all outputs this cycle.
- flush_i  in  1  replace stage contents with a bubble.
- valid_i  in  1  ID holds a real instruction.
- rs1_data_i, rs2_data_i, Iimm_i, Simm_i  in  XLEN each  ID operands and immediates.
- rs1_addr_i, rs2_addr_i, rd_addr_i  in  RA_W each  register addresses.
- funct3_i  in  3  instruction funct3 field.
- funct7_i  in  7  instruction funct7 field.
- ALUOp_i  in  2  00=add, 01=sub, 10=R-type, 11=I-type arithmetic.
- ALUSrc_i  in  1  1 selects Iimm_i as val2.
- WB_i  in  1  writeback enable.
- Mem_i  in  2  memory control.
- valid_o  out  1  EX holds a real instruction.
- val1_o, val2_o  out  XLEN each  ALU operands.
- rs2_data_o  out  XLEN  unmuxed rs2 data, used as store data.
- Simm_o  out  XLEN  store immediate.
- rs1_addr_o, rs2_addr_o, rd_addr_o  out  RA_W each  addresses, for forwarding.
- ALUCtrl_o  out  4  registered ALU code.
- WB_o  out  1  writeback enable.
- Mem_o  out  2  memory control.
- illegal_o  out  1  registered illegal-decode flag.
- bubble_cnt_o  out  CNT_W  count of bubbles inserted.

Behaviour:
- Reset (rst_i=0), asynchronous:
  - All outputs 0, including valid_o, illegal_o and bubble_cnt_o.
  - Holds while asserted.
- Posedge update priority is flush > stall > load.
- Flush:
  - valid_o, WB_o, Mem_o and illegal_o become 0.
  - ALUCtrl_o=0010; data and address outputs become 0.
  - bubble_cnt_o increments.
- Stall (no flush):
  - Every output, including bubble_cnt_o, holds its value.
- Load with valid_i=1:
  - val1_o←rs1_data_i; val2_o←ALUSrc_i ? Iimm_i : rs2_data_i.
  - rs2_data_o←rs2_data_i; Simm_o←Simm_i; addresses copied.
  - WB_o←WB_i; Mem_o←Mem_i; ALUCtrl_o←decode; illegal_o←illegal.
  - valid_o←1.
- Load with valid_i=0:
  - Same result as flush, and bubble_cnt_o increments.
- Latency: 1 cycle. No combinational path from any input to any output.
- ALU decode is combinational and registered at load. Codes: AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SRA 0111, SLT 1000, MUL 1111.
- ALUOp 00 → ADD; ALUOp 01 → SUB.
- ALUOp 10, key {funct7,funct3}:
  - 0000000_000 ADD; 0100000_000 SUB; 0000000_111 AND; 0000000_110 OR.
  - 0000000_100 XOR; 0000000_001 SLL; 0000000_101 SRL; 0100000_101 SRA.
  - 0000000_010 SLT; 0000001_000 MUL.
- ALUOp 11, by funct3:
  - 000 ADD; 111 AND; 110 OR; 100 XOR; 010 SLT.
  - 001 SLL only if funct7=0000000.
  - 101 SRL if funct7=0000000; SRA if funct7=0100000.
- Any other combination is illegal:
  - ALUCtrl=ADD, illegal=1.
  - Captured WB_o=0 and Mem_o=00, so there are no side effects.
  - valid_o=1, so the trap logic can see it.
- Decode is fully specified; no latch inference.
- bubble_cnt_o saturates at all-ones; no wrap.
- Simultaneous flush+stall: flush wins.
- Reset asserted mid-stall: outputs clear immediately; the first clock after release performs a normal load.

Test Plan:
- Reset, then load ALUOp=10, funct7=0100000, funct3=000, rs1=7, rs2=3, ALUSrc=0 → next edge: val1_o=7, val2_o=3, ALUCtrl_o=0110, valid_o=1, illegal_o=0.
- ALUOp=11, funct3=101, funct7=0100000, ALUSrc=1, Iimm=4, rs2=9 → ALUCtrl_o=0111, val2_o=4, rs2_data_o=9.
- Load rd=5, WB=1, then stall for 3 cycles while inputs change to rd=9 → rd_addr_o stays 5 and WB_o stays 1 for 3 cycles; after release rd_addr_o=9.
- flush_i=1 and stall_i=1 together with WB_i=1, Mem_i=01 → valid_o=0, WB_o=0, Mem_o=0, bubble_cnt_o increments 0→1.
- ALUOp=10, funct7=0000010, funct3=000, WB=1, Mem=10 → illegal_o=1, ALUCtrl_o=0010, WB_o=0, Mem_o=00, valid_o=1.
- CNT_W=2 with 5 consecutive valid_i=0 loads → bubble_cnt_o goes 1,2,3,3,3; async rst_i low mid-cycle → all outputs 0 immediately.
